// File: rtl/data_cache.sv
// data_cache: direct-mapped, one-word-per-line, write-through / no-allocate data cache.
// Latency: read hit returns data the cycle after the request; misses and writes stall until memory completes.
// Backpressure: stall holds the CPU while a memory request is pending; mem_req_* stay stable until mem_req_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   dcache_addr/we/re/din CPU request (byte address, byte write mask, read strobe, write data)
//   dcache_dout, stall    read data (held until the next read completes), CPU hold
//   mem_req_*             single outstanding request to backing memory (word address)
//   mem_resp_valid/data   read response, only consumed while waiting for a fill
module data_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic [3:0]  dcache_we,
  input  logic        dcache_re,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 30 - IDX;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_REQ  = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_WR_REQ  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Registered request: word address, write data and mask of the accepted access.
  logic [29:0] req_waddr_q;
  logic [31:0] req_din_q;
  logic [3:0]  req_we_q;
  logic [31:0] dout_q;

  // Byte offset is irrelevant for a word-organised cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dcache_addr[1:0];

  logic [IDX-1:0]  in_idx;
  logic [TAGW-1:0] in_tag;
  logic            in_hit;
  logic            accept;
  logic            wr_req;
  logic            rd_req;
  logic            fill;
  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;

  assign in_idx  = dcache_addr[IDX+1:2];
  assign in_tag  = dcache_addr[31:IDX+2];
  assign in_hit  = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

  // Inputs are only looked at while the cache is idle (stall low); writes win over reads.
  assign accept  = (state_q == S_IDLE);
  assign wr_req  = accept && (dcache_we != 4'b0000);
  assign rd_req  = accept && dcache_re && (dcache_we == 4'b0000);

  assign req_idx = req_waddr_q[IDX-1:0];
  assign req_tag = req_waddr_q[29:IDX];
  assign fill    = (state_q == S_RD_WAIT) && mem_resp_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          state_d = S_WR_REQ;
        end else if (rd_req && !in_hit) begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (mem_req_ready)  state_d = S_RD_WAIT;
      S_RD_WAIT: if (mem_resp_valid) state_d = S_IDLE;
      S_WR_REQ:  if (mem_req_ready)  state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      req_waddr_q <= '0;
      req_din_q   <= '0;
      req_we_q    <= '0;
      dout_q      <= '0;
    end else begin
      state_q <= state_d;
      if (wr_req || rd_req) begin
        req_waddr_q <= dcache_addr[31:2];
        req_din_q   <= dcache_din;
        req_we_q    <= dcache_we;
      end
      if (rd_req && in_hit) begin
        dout_q <= data_q[in_idx];
      end
      if (fill) begin
        valid_q[req_idx] <= 1'b1;
        dout_q           <= mem_resp_data;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (wr_req && in_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (dcache_we[b]) begin
          data_q[in_idx][8*b +: 8] <= dcache_din[8*b +: 8];
        end
      end
    end
    if (fill) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mem_resp_data;
    end
  end

  // Everything below derives from registered state, so requests are stable under backpressure.
  assign stall         = (state_q != S_IDLE);
  assign mem_req_valid = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign mem_req_rw    = (state_q == S_WR_REQ);
  assign mem_req_addr  = req_waddr_q;
  assign mem_req_data  = req_din_q;
  assign mem_req_mask  = req_we_q;
  assign dcache_dout   = dout_q;

endmodule
